// File: rtl/fdc_disk_sequencer.sv
// rtl/fdc_disk_sequencer.sv - FDC disk-side back end: request decode, host transactions, sector byte streaming
// Optional feature macro: SEEK_DELAY_EN (per-drive track registers and timed seek steps)
module fdc_disk_sequencer #(
  parameter int          SECTOR_BYTES = 512,
  parameter logic [23:0] TIMEOUT      = 24'hFFFFFF,
  parameter logic [15:0] SEEK_DELAY   = 16'd4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] disk_sr,
  output logic [31:0] disk_cr,
  output logic [7:0]  disk_data_in,
  output logic        disk_data_clkin,
  input  logic [7:0]  disk_data_out,
  output logic        disk_data_clkout,
  input  logic [1:0]  disk_present,
  output logic        host_req,
  output logic [1:0]  host_op,
  output logic        host_drive,
  output logic        host_head,
  output logic [6:0]  host_track,
  output logic [7:0]  host_sector,
  input  logic        host_ack,
  input  logic        host_err,
  input  logic        host_wp,
  input  logic [7:0]  host_sectid,
  input  logic [7:0]  host_rd_data,
  input  logic        host_rd_valid,
  output logic        host_rd_ready,
  output logic [7:0]  host_wr_data,
  output logic        host_wr_valid,
  input  logic        host_wr_ready
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_HDR       = 4'd1;
  localparam logic [3:0] S_RD_STREAM = 4'd2;
  localparam logic [3:0] S_RD_PAD    = 4'd3;
  localparam logic [3:0] S_WR_PULL   = 4'd4;
  localparam logic [3:0] S_WR_CAP    = 4'd5;
  localparam logic [3:0] S_WR_HOLD   = 4'd6;
  localparam logic [3:0] S_DONE_HOLD = 4'd7;
  localparam logic [3:0] S_SEEK_WAIT = 4'd8;

  localparam logic [1:0] OP_SEEK   = 2'd0;
  localparam logic [1:0] OP_READID = 2'd1;
  localparam logic [1:0] OP_READ   = 2'd2;
  localparam logic [1:0] OP_WRITE  = 2'd3;

  localparam logic [9:0] LAST_BYTE = 10'(SECTOR_BYTES - 1);

  logic [3:0]  state;
  logic [1:0]  op;
  logic        drive;
  logic        head;
  logic [6:0]  track;
  logic [7:0]  sector;
  logic [7:0]  sectid;
  logic        err_f;
  logic        wperr_f;
  logic [9:0]  byte_cnt;
  logic [23:0] tmo_cnt;
  logic        rd_strobe;
  logic [7:0]  rd_byte;
  logic [7:0]  wr_byte;
  logic        wr_valid;

  logic [1:0]  req_op;
  logic [1:0]  req_bits;
  logic        req_drive;
  logic        req_head;
  logic        req_any;
  logic        tmo_hit;
  logic        last_byte;
  logic        in_done;

  logic        unused_sr;
  assign unused_sr = ^{disk_sr[31:26], disk_sr[19]};

`ifdef SEEK_DELAY_EN
  logic [6:0]  cur_track [2];
  logic [6:0]  seek_dist;
  logic [22:0] seek_cnt;
  assign seek_dist = (track >= cur_track[drive]) ? (track - cur_track[drive])
                                                 : (cur_track[drive] - track);
`else
  logic        unused_seek_delay;
  assign unused_seek_delay = ^SEEK_DELAY;
`endif

  // Request decode: seek > readid > read > write; read header keeps the FDC's bit-14 overlap
  always_comb begin
    req_op   = OP_WRITE;
    req_bits = disk_sr[21:20];
    if (|disk_sr[25:24]) begin
      req_op   = OP_SEEK;
      req_bits = disk_sr[25:24];
    end else if (|disk_sr[23:22]) begin
      req_op   = OP_READID;
      req_bits = disk_sr[23:22];
    end else if (|disk_sr[18:17]) begin
      req_op   = OP_READ;
      req_bits = disk_sr[18:17];
    end
    req_drive = ~req_bits[0];
    req_head  = (req_op == OP_READ) ? disk_sr[14] : disk_sr[15];
  end

  assign req_any   = |{disk_sr[25:20], disk_sr[18:17]};
  assign tmo_hit   = (tmo_cnt == 24'd0);
  assign last_byte = (byte_cnt == LAST_BYTE);
  assign in_done   = (state == S_DONE_HOLD);

  assign host_req         = (state == S_HDR);
  assign host_op          = op;
  assign host_drive       = drive;
  assign host_head        = head;
  assign host_track       = track;
  assign host_sector      = sector;
  assign host_rd_ready    = (state == S_RD_STREAM);
  assign host_wr_data     = wr_byte;
  assign host_wr_valid    = wr_valid;
  assign disk_data_in     = rd_byte;
  assign disk_data_clkin  = rd_strobe;
  assign disk_data_clkout = (state == S_WR_PULL);

  assign disk_cr = {in_done ? sectid : 8'h00, 8'h00, 7'h00, in_done & head, 1'b0, disk_present,
                    in_done && (op != OP_SEEK), in_done & err_f, in_done & wperr_f,
                    (in_done && (op == OP_SEEK)) ? {drive, ~drive} : 2'b00};

  // Command sequencer: header handshake, byte streaming, timeout recovery, completion hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op        <= OP_SEEK;
      drive     <= 1'b0;
      head      <= 1'b0;
      track     <= 7'd0;
      sector    <= 8'd0;
      sectid    <= 8'd0;
      err_f     <= 1'b0;
      wperr_f   <= 1'b0;
      byte_cnt  <= 10'd0;
      tmo_cnt   <= 24'd0;
      rd_strobe <= 1'b0;
      rd_byte   <= 8'd0;
      wr_byte   <= 8'd0;
      wr_valid  <= 1'b0;
`ifdef SEEK_DELAY_EN
      cur_track[0] <= 7'd0;
      cur_track[1] <= 7'd0;
      seek_cnt     <= 23'd0;
`endif
    end else begin
      rd_strobe <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!disk_sr[16] && req_any) begin
            op       <= req_op;
            drive    <= req_drive;
            head     <= req_head;
            track    <= disk_sr[14:8];
            sector   <= disk_sr[7:0];
            sectid   <= 8'd0;
            byte_cnt <= 10'd0;
            tmo_cnt  <= TIMEOUT;
            if (!disk_present[req_drive]) begin
              err_f <= 1'b1;
              state <= S_DONE_HOLD;
            end else begin
              state <= S_HDR;
            end
          end
        end
        S_HDR: begin
          if (host_ack) begin
            sectid  <= host_sectid;
            err_f   <= host_err;
            tmo_cnt <= TIMEOUT;
            case (op)
              OP_SEEK: begin
`ifdef SEEK_DELAY_EN
                seek_cnt         <= 23'(seek_dist) * 23'(SEEK_DELAY);
                cur_track[drive] <= track;
                state            <= S_SEEK_WAIT;
`else
                state <= S_DONE_HOLD;
`endif
              end
              OP_READID: state <= S_DONE_HOLD;
              OP_READ:   state <= host_err ? S_DONE_HOLD : S_RD_STREAM;
              default: begin
                if (host_wp) begin
                  err_f   <= 1'b1;
                  wperr_f <= 1'b1;
                  state   <= S_DONE_HOLD;
                end else begin
                  state <= S_WR_PULL;
                end
              end
            endcase
          end else if (tmo_hit) begin
            err_f <= 1'b1;
            state <= (op == OP_READ) ? S_RD_PAD : S_DONE_HOLD;
          end else begin
            tmo_cnt <= tmo_cnt - 24'd1;
          end
        end
        S_RD_STREAM: begin
          if (host_rd_valid) begin
            rd_byte   <= host_rd_data;
            rd_strobe <= 1'b1;
            tmo_cnt   <= TIMEOUT;
            if (byte_cnt != 10'h3FF) byte_cnt <= byte_cnt + 10'd1;
            if (last_byte) state <= S_DONE_HOLD;
          end else if (tmo_hit) begin
            err_f <= 1'b1;
            state <= S_RD_PAD;
          end else begin
            tmo_cnt <= tmo_cnt - 24'd1;
          end
        end
        S_RD_PAD: begin
          // Fill the rest of the FDC read FIFO so it never waits on a short sector
          rd_byte   <= 8'hE5;
          rd_strobe <= 1'b1;
          if (byte_cnt != 10'h3FF) byte_cnt <= byte_cnt + 10'd1;
          if (last_byte) state <= S_DONE_HOLD;
        end
        S_WR_PULL: begin
          tmo_cnt <= TIMEOUT;
          state   <= S_WR_CAP;
        end
        S_WR_CAP: begin
          wr_byte  <= disk_data_out;
          wr_valid <= 1'b1;
          state    <= S_WR_HOLD;
        end
        S_WR_HOLD: begin
          if (host_wr_ready) begin
            wr_valid <= 1'b0;
            tmo_cnt  <= TIMEOUT;
            if (byte_cnt != 10'h3FF) byte_cnt <= byte_cnt + 10'd1;
            state <= last_byte ? S_DONE_HOLD : S_WR_PULL;
          end else if (tmo_hit) begin
            wr_valid <= 1'b0;
            err_f    <= 1'b1;
            state    <= S_DONE_HOLD;
          end else begin
            tmo_cnt <= tmo_cnt - 24'd1;
          end
        end
`ifdef SEEK_DELAY_EN
        S_SEEK_WAIT: begin
          if (seek_cnt <= 23'd1) state <= S_DONE_HOLD;
          else seek_cnt <= seek_cnt - 23'd1;
        end
`endif
        S_DONE_HOLD: begin
          if (!req_any && disk_sr[16]) begin
            err_f   <= 1'b0;
            wperr_f <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdc_disk_sequencer.sv
// tb/tb_fdc_disk_sequencer.sv - vector table plus byte-stream scoreboard for fdc_disk_sequencer
module tb_fdc_disk_sequencer;

  localparam int NB = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] disk_sr;
  logic [31:0] disk_cr;
  logic [7:0]  disk_data_in;
  logic        disk_data_clkin;
  logic [7:0]  disk_data_out;
  logic        disk_data_clkout;
  logic [1:0]  disk_present;
  logic        host_req;
  logic [1:0]  host_op;
  logic        host_drive;
  logic        host_head;
  logic [6:0]  host_track;
  logic [7:0]  host_sector;
  logic        host_ack;
  logic        host_err;
  logic        host_wp;
  logic [7:0]  host_sectid;
  logic [7:0]  host_rd_data;
  logic        host_rd_valid;
  logic        host_rd_ready;
  logic [7:0]  host_wr_data;
  logic        host_wr_valid;
  logic        host_wr_ready;

  always #5 clk = ~clk;

  fdc_disk_sequencer #(.SECTOR_BYTES(NB), .TIMEOUT(24'd64), .SEEK_DELAY(16'd10)) dut (
    .clk(clk), .rst_n(rst_n), .disk_sr(disk_sr), .disk_cr(disk_cr),
    .disk_data_in(disk_data_in), .disk_data_clkin(disk_data_clkin),
    .disk_data_out(disk_data_out), .disk_data_clkout(disk_data_clkout),
    .disk_present(disk_present), .host_req(host_req), .host_op(host_op),
    .host_drive(host_drive), .host_head(host_head), .host_track(host_track),
    .host_sector(host_sector), .host_ack(host_ack), .host_err(host_err),
    .host_wp(host_wp), .host_sectid(host_sectid), .host_rd_data(host_rd_data),
    .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
    .host_wr_data(host_wr_data), .host_wr_valid(host_wr_valid),
    .host_wr_ready(host_wr_ready)
  );

  logic [39:0] outs;
  assign outs = {host_req, host_op, host_drive, host_head, host_track, host_sector, host_rd_ready,
                 host_wr_data, host_wr_valid, disk_data_in, disk_data_clkin, disk_data_clkout};

  typedef struct {
    string       name;
    logic [31:0] sr;
    logic [1:0]  present;
    logic        err;
    logic        wp;
    logic [7:0]  sectid;
    logic        exp_req;
    logic [1:0]  exp_op;
    logic        exp_drive;
    logic        exp_head;
    logic [6:0]  exp_track;
    logic [7:0]  exp_sector;
    logic [31:0] exp_cr;
  } vec_t;

  vec_t       vecs [10];
  int         n_tests = 0;
  int         n_fail = 0;
  int         n_clkin = 0;
  int         n_clkout = 0;
  int         widx = 0;
  logic [7:0] rd_q [$];
  logic [7:0] wr_q [$];
  logic [8:0] rd_exp;
  logic [8:0] wr_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] wbyte(input int k);
    return 8'((k * 13 + 5) & 255);
  endfunction

  function automatic bit done_seen();
    return disk_cr[4] || (disk_cr[1:0] != 2'b00);
  endfunction

  // Read-FIFO scoreboard and host write-side scoreboard
  always @(negedge clk) begin
    if (rst_n && disk_data_clkin) begin
      n_clkin++;
      rd_exp = (rd_q.size() != 0) ? {1'b0, rd_q.pop_front()} : 9'h100;
      check("rd_byte", {1'b0, disk_data_in}, rd_exp);
    end
    if (rst_n && host_wr_valid && host_wr_ready) begin
      wr_exp = (wr_q.size() != 0) ? {1'b0, wr_q.pop_front()} : 9'h100;
      check("wr_byte", {1'b0, host_wr_data}, wr_exp);
    end
  end

  // FDC write FIFO model: next byte appears just after the edge that ends the read strobe
  always @(negedge clk) begin
    if (rst_n && disk_data_clkout) begin
      n_clkout++;
      @(posedge clk);
      #1;
      disk_data_out = wbyte(widx);
      wr_q.push_back(wbyte(widx));
      widx++;
    end
  end

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (host_req) begin
        got = 1'b1;
        break;
      end
      if (done_seen()) break;
    end
  endtask

  task automatic ack_host(input int dly, input logic err, input logic wp, input logic [7:0] sid);
    repeat (dly) @(posedge clk);
    #1;
    host_ack = 1'b1; host_err = err; host_wp = wp; host_sectid = sid;
    @(posedge clk);
    #1;
    host_ack = 1'b0; host_err = 1'b0; host_wp = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (done_seen()) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic release_fdc(input string name);
    @(posedge clk);
    #1 disk_sr = 32'h0001_0000;
    repeat (2) @(negedge clk);
    check({name, "_cleared"}, disk_cr, {25'b0, disk_present, 5'b0});
    @(posedge clk);
    #1 disk_sr = 32'h0;
  endtask

  task automatic stream_bytes(input int first, input int count, input int maxgap);
    for (int i = first; i < first + count; i++) begin
      repeat ($urandom_range(maxgap, 0)) @(posedge clk);
      #1;
      host_rd_valid = 1'b1;
      host_rd_data  = 8'(i);
      rd_q.push_back(8'(i));
      @(posedge clk);
      #1 host_rd_valid = 1'b0;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bit ok;
    int ci;
    int co;

    //            name          sr            pres   err   wp    sid    req   op    drv   hd    trk     sec     cr
    vecs[0] = '{"seek_d0",     32'h01000500, 2'b11, 1'b0, 1'b0, 8'h11, 1'b1, 2'd0, 1'b0, 1'b0, 7'h05, 8'h00, 32'h11000061};
    vecs[1] = '{"seek_d1",     32'h0200FF42, 2'b11, 1'b0, 1'b0, 8'h22, 1'b1, 2'd0, 1'b1, 1'b1, 7'h7F, 8'h42, 32'h22000162};
    vecs[2] = '{"readid_d0",   32'h00408307, 2'b11, 1'b0, 1'b0, 8'h5A, 1'b1, 2'd1, 1'b0, 1'b1, 7'h03, 8'h07, 32'h5A000170};
    vecs[3] = '{"readid_err",  32'h00800901, 2'b11, 1'b1, 1'b0, 8'h33, 1'b1, 2'd1, 1'b1, 1'b0, 7'h09, 8'h01, 32'h33000078};
    vecs[4] = '{"read_err",    32'h000245C3, 2'b11, 1'b1, 1'b0, 8'h00, 1'b1, 2'd2, 1'b0, 1'b1, 7'h45, 8'hC3, 32'h00000178};
    vecs[5] = '{"write_wp",    32'h00208204, 2'b11, 1'b0, 1'b1, 8'h04, 1'b1, 2'd3, 1'b1, 1'b1, 7'h02, 8'h04, 32'h0400017C};
    vecs[6] = '{"read_nodisk", 32'h000400C3, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 7'h00, 8'h00, 32'h00000018};
    vecs[7] = '{"seek_nodisk", 32'h01000500, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 7'h00, 8'h00, 32'h00000049};
    vecs[8] = '{"prio_seek",   32'h01040300, 2'b11, 1'b0, 1'b0, 8'h99, 1'b1, 2'd0, 1'b0, 1'b0, 7'h03, 8'h00, 32'h99000061};
    vecs[9] = '{"prio_readid", 32'h00900100, 2'b11, 1'b0, 1'b0, 8'h01, 1'b1, 2'd1, 1'b1, 1'b0, 7'h01, 8'h00, 32'h01000070};

    rst_n = 1'b0; disk_sr = 32'h0; disk_present = 2'b10; disk_data_out = 8'h00;
    host_ack = 1'b0; host_err = 1'b0; host_wp = 1'b0; host_sectid = 8'h00;
    host_rd_data = 8'h00; host_rd_valid = 1'b0; host_wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs, 40'h0);
    check("reset_cr", disk_cr, 32'h00000040);
    rst_n = 1'b1;
    disk_present = 2'b11;
    @(posedge clk);

    for (int i = 0; i < 10; i++) begin
      ci = n_clkin;
      co = n_clkout;
      #1;
      disk_present = vecs[i].present;
      @(posedge clk);
      #1 disk_sr = vecs[i].sr;
      wait_req(got);
      check({vecs[i].name, "_req"}, got, vecs[i].exp_req);
      if (got) begin
        check({vecs[i].name, "_hdr"}, {host_op, host_drive, host_head, host_track, host_sector},
              {vecs[i].exp_op, vecs[i].exp_drive, vecs[i].exp_head, vecs[i].exp_track, vecs[i].exp_sector});
        ack_host(3, vecs[i].err, vecs[i].wp, vecs[i].sectid);
      end
      wait_done(50, ok);
      check({vecs[i].name, "_done"}, ok, 1'b1);
      check({vecs[i].name, "_cr"}, disk_cr, vecs[i].exp_cr);
      check({vecs[i].name, "_strobes"}, {n_clkin - ci, n_clkout - co}, 64'h0);
      release_fdc(vecs[i].name);
      @(posedge clk);
    end
    #1 disk_present = 2'b11;

    // Full read on drive 1 with random valid gaps
    ci = n_clkin;
    @(posedge clk);
    #1 disk_sr = 32'h000410C3;
    wait_req(got);
    check("rd_req", got, 1'b1);
    check("rd_hdr", {host_op, host_drive, host_track, host_sector}, {2'd2, 1'b1, 7'h10, 8'hC3});
    ack_host(2, 1'b0, 1'b0, 8'hC3);
    stream_bytes(0, NB, 3);
    wait_done(50, ok);
    check("rd_done", ok, 1'b1);
    check("rd_count", n_clkin - ci, NB);
    check("rd_left", rd_q.size(), 0);
    check("rd_status", {disk_cr[31:24], disk_cr[4:2]}, {8'hC3, 3'b100});
    release_fdc("rd");

    // Full write on drive 0, host stalls 10 cycles per byte, request dropped early
    co = n_clkout;
    widx = 0;
    @(posedge clk);
    #1 disk_sr = 32'h00100301;
    wait_req(got);
    check("wr_req", got, 1'b1);
    check("wr_hdr", {host_op, host_drive, host_track, host_sector}, {2'd3, 1'b0, 7'h03, 8'h01});
    ack_host(1, 1'b0, 1'b0, 8'h01);
    disk_sr = 32'h0;
    for (int k = 0; k < NB; k++) begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (host_wr_valid) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        check("wr_valid_wait", seen, 1'b1);
        break;
      end
      repeat (10) @(posedge clk);
      #1 host_wr_ready = 1'b1;
      @(posedge clk);
      #1 host_wr_ready = 1'b0;
    end
    wait_done(50, ok);
    check("wr_done", ok, 1'b1);
    check("wr_count", n_clkout - co, NB);
    check("wr_left", wr_q.size(), 0);
    check("wr_status", disk_cr[4:2], 3'b100);
    release_fdc("wr");

    // Host goes silent after byte 100: remaining 411 bytes padded with E5
    ci = n_clkin;
    @(posedge clk);
    #1 disk_sr = 32'h0002002A;
    wait_req(got);
    check("tmo_req", got, 1'b1);
    ack_host(1, 1'b0, 1'b0, 8'h2A);
    stream_bytes(0, 101, 0);
    repeat (NB - 101) rd_q.push_back(8'hE5);
    wait_done(800, ok);
    check("tmo_done", ok, 1'b1);
    check("tmo_count", n_clkin - ci, NB);
    check("tmo_left", rd_q.size(), 0);
    check("tmo_status", disk_cr[4:2], 3'b110);
    release_fdc("tmo");

    // Seek with no host_ack: header timeout gives an error completion
    @(posedge clk);
    #1 disk_sr = 32'h01000200;
    wait_req(got);
    check("hdr_tmo_req", got, 1'b1);
    wait_done(150, ok);
    check("hdr_tmo_done", ok, 1'b1);
    check("hdr_tmo_status", {host_req, disk_cr[4:3], disk_cr[1:0]}, 5'b00101);
    release_fdc("hdr_tmo");

    // Reset asserted mid-stream clears every output at once
    @(posedge clk);
    #1 disk_sr = 32'h00020000;
    wait_req(got);
    check("rst_req", got, 1'b1);
    ack_host(1, 1'b0, 1'b0, 8'h00);
    stream_bytes(0, 50, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_outputs", outs, 40'h0);
    check("rst_cr", disk_cr, 32'h00000060);
    disk_sr = 32'h0;
    rd_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_idle", {outs, disk_cr}, {40'h0, 32'h00000060});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
